// File: rtl/req_arbiter8.sv
// req_arbiter8: 8-requester arbiter with hold timer and 1-cycle registered grant.
// Define REQ_ARBITER8_ROUND_ROBIN_EN for rotating priority; default is fixed (7 highest).
module req_arbiter8 #(
    parameter int MAX_HOLD = 15,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic       tout
);

    typedef enum logic {IDLE, GRANT} state_e;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_e            state_q, state_d;
    logic [7:0]        gnt_q, gnt_d;
    logic [2:0]        idx_q, idx_d;
    logic              tout_q, tout_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [7:0]        cand;
    logic              do_grant;

`ifdef REQ_ARBITER8_ROUND_ROBIN_EN
    logic [2:0] rr_q, rr_d;

    // Search descends from ptr-1 and wraps, so ptr itself is examined last.
    function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] ptr);
        logic [2:0] w;
        logic [2:0] p;
        w = 3'd0;
        for (int k = 8; k >= 1; k--) begin
            p = ptr - 3'(k);
            if (r[p]) w = p;
        end
        return w;
    endfunction
`else
    function automatic logic [2:0] pick(input logic [7:0] r);
        logic [2:0] w;
        w = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (r[i]) w = 3'(i);
        end
        return w;
    endfunction
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        tout_d   = 1'b0;
        cand     = req;
        do_grant = 1'b0;
`ifdef REQ_ARBITER8_ROUND_ROBIN_EN
        rr_d     = rr_q;
`endif
        case (state_q)
            IDLE: begin
                hold_d = '0;
                if (|req) do_grant = 1'b1;
            end
            GRANT: begin
                if (!req[idx_q] || hold_q == HOLD_LAST) begin
                    // Owner still requesting here means the timer forced the release.
                    tout_d = req[idx_q];
                    cand   = req & ~(8'd1 << idx_q);
                    if (|cand) do_grant = 1'b1;
                    else       state_d  = IDLE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (do_grant) begin
            state_d = GRANT;
            hold_d  = '0;
`ifdef REQ_ARBITER8_ROUND_ROBIN_EN
            idx_d   = pick(cand, rr_q);
            rr_d    = idx_d;
`else
            idx_d   = pick(cand);
`endif
        end
        gnt_d = (state_d == GRANT) ? (8'd1 << idx_d) : 8'h00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 8'h00;
            idx_q   <= 3'd0;
            tout_q  <= 1'b0;
            hold_q  <= '0;
`ifdef REQ_ARBITER8_ROUND_ROBIN_EN
            rr_q    <= 3'd7;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            tout_q  <= tout_d;
            hold_q  <= hold_d;
`ifdef REQ_ARBITER8_ROUND_ROBIN_EN
            rr_q    <= rr_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign gnt_vld = (state_q == GRANT);
    assign tout    = tout_q;

endmodule

// File: tb/tb_req_arbiter8.sv
// Scoreboard bench for req_arbiter8 (MAX_HOLD=4): a cycle model predicts outputs,
// a negedge monitor compares; directed checks cover the documented scenarios.
module tb_req_arbiter8;

    localparam int MH = 4;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       tout;

    int n_chk  = 0;
    int n_fail = 0;

    logic [12:0] exp_q[$];
    logic [12:0] dut_out;
    logic [12:0] rst_out;

    req_arbiter8 #(.MAX_HOLD(MH), .HOLD_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .tout    (tout)
    );

    assign dut_out = {gnt, gnt_idx, gnt_vld, tout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got gnt=%h idx=%0d vld=%0d tout=%0d, want gnt=%h idx=%0d vld=%0d tout=%0d",
                     nm, act[12:5], act[4:2], act[1], act[0], exp[12:5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    // Reference model: owner as an integer (-1 = none), cycles-held counter.
    int m_own  = -1;
    int m_last = 0;
    int m_cnt  = 0;
    bit m_tout = 0;
`ifdef REQ_ARBITER8_ROUND_ROBIN_EN
    int m_rr   = 7;

    function automatic int mpick(input logic [7:0] r);
        for (int k = 1; k <= 8; k++) begin
            if (r[(m_rr - k + 8) % 8]) return (m_rr - k + 8) % 8;
        end
        return -1;
    endfunction
`else
    function automatic int mpick(input logic [7:0] r);
        for (int p = 7; p >= 0; p--) begin
            if (r[p]) return p;
        end
        return -1;
    endfunction
`endif

    function automatic logic [12:0] mexp();
        logic [7:0] g;
        g = (m_own >= 0) ? (8'd1 << m_own) : 8'h00;
        return {g, 3'(m_last), (m_own >= 0), m_tout};
    endfunction

    task automatic model_grant(input logic [7:0] c);
        int w;
        w = mpick(c);
        m_own  = w;
        m_last = w;
        m_cnt  = 0;
`ifdef REQ_ARBITER8_ROUND_ROBIN_EN
        m_rr   = w;
`endif
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] c;
        bit vol, tmo;
        forever begin
            @(posedge clk);
            r = req;
            if (rst) begin
                m_own = -1; m_last = 0; m_cnt = 0; m_tout = 0;
`ifdef REQ_ARBITER8_ROUND_ROBIN_EN
                m_rr = 7;
`endif
            end else if (m_own < 0) begin
                m_tout = 0;
                if (r != 0) model_grant(r);
            end else begin
                vol = !r[m_own];
                tmo = (m_cnt + 1 >= MH);
                if (vol || tmo) begin
                    m_tout = tmo && !vol;
                    c = r;
                    c[m_own] = 1'b0;
                    if (c != 0) model_grant(c);
                    else        m_own = -1;
                end else begin
                    m_cnt++;
                    m_tout = 0;
                end
            end
            exp_q.push_back(mexp());
        end
    end

    // Monitor: one prediction per clock edge, compared mid-cycle.
    initial begin
        logic [12:0] e;
        rst_out = 13'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                chk("reset_hold", dut_out, rst_out);
            end else if (exp_q.size() == 0) begin
                chk("scoreboard_empty", dut_out, 13'h1fff);
            end else begin
                e = exp_q.pop_front();
                chk("scoreboard", dut_out, e);
            end
        end
    end

    task automatic step(input logic [7:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic dchk(input string nm, input logic [7:0] g, input logic [2:0] i,
                        input logic v, input logic t);
`ifndef REQ_ARBITER8_ROUND_ROBIN_EN
        chk(nm, dut_out, {g, i, v, t});
`endif
    endtask

    initial begin
        logic [7:0] r;
        rst = 1'b1;
        req = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", dut_out, 13'd0);
        rst = 1'b0;

        step(8'h26);  dchk("priority", 8'h20, 3'd5, 1'b1, 1'b0);
        step(8'h06);  dchk("handoff", 8'h04, 3'd2, 1'b1, 1'b0);
        step(8'h00);  dchk("handoff_idle", 8'h00, 3'd2, 1'b0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            step(8'h81);
            dchk("timeout_hold7", 8'h80, 3'd7, 1'b1, 1'b0);
        end
        step(8'h81);  dchk("timeout_to0", 8'h01, 3'd0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(8'h81);
            dchk("timeout_hold0", 8'h01, 3'd0, 1'b1, 1'b0);
        end
        step(8'h81);  dchk("timeout_to7", 8'h80, 3'd7, 1'b1, 1'b1);
        step(8'h00);  dchk("timeout_idle", 8'h00, 3'd7, 1'b0, 1'b0);

        step(8'h08);  dchk("idle_ret_a", 8'h08, 3'd3, 1'b1, 1'b0);
        step(8'h08);  dchk("idle_ret_b", 8'h08, 3'd3, 1'b1, 1'b0);
        step(8'h00);  dchk("idle_ret_c", 8'h00, 3'd3, 1'b0, 1'b0);

        step(8'hFF);
        step(8'hFF);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", dut_out, 13'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        r = 8'hFF;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 7))
                0:       r = 8'( 1 << $urandom_range(0, 7));
                1:       r = 8'($urandom);
                2:       r = 8'h00;
                3, 4:    r[$urandom_range(0, 7)] = ~r[$urandom_range(0, 7)];
                default: r = r;
            endcase
            step(r);
        end

        step(8'h00);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/req_arbiter8.md
Name: req_arbiter8

Overview:
- Sequential 8-requester arbiter built around 8-to-3 priority encoding (I[7] highest, I[0] lowest).
- Grants one shared resource to one requester at a time.
- Holds the grant until the owner releases it or a hold timer expires.
- Sits in front of any shared datapath, e.g. a shared bus or display driver, and produces both a one-hot grant and the binary owner index.

Parameters:
- MAX_HOLD, 15: maximum consecutive cycles one owner keeps the grant. Legal range 1..2^HOLD_W-1.
- HOLD_W, 4: width of the internal hold counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- req  input  8  request vector, active-high; req[i] = requester i wants the resource.
- gnt  output  8  one-hot grant, registered; all-zero when no owner.
- gnt_idx  output  3  binary index of the current owner, registered; valid only while gnt_vld=1.
- gnt_vld  output  1  high while any grant is held.
- tout  output  1  one-cycle pulse in the first cycle after a grant was forcibly released by the hold timer.

Behaviour:
- Fully synchronous except reset. rst=1 asynchronously forces the following, regardless of state:
  - state=IDLE, gnt=8'h00, gnt_idx=3'd0, gnt_vld=0, tout=0.
  - hold_cnt=0, rr_ptr=3'd7.
- Two states: IDLE, GRANT.
- IDLE:
  - req==0 -> stay in IDLE.
  - req!=0 -> next edge enters GRANT with winner = highest-priority set bit.
  - Latency is 1 cycle: req sampled at edge n, gnt visible after edge n.
  - hold_cnt loads 0.
- GRANT:
  - Owner index o is held in gnt_idx; gnt=1<<o.
  - hold_cnt increments each cycle the grant is held. The first grant cycle has hold_cnt=0.
  - Release occurs at the edge where req[o]==0 (voluntary) or hold_cnt==MAX_HOLD-1 (timeout). The grant is therefore never asserted more than MAX_HOLD cycles.
  - Voluntary release takes precedence if both conditions are true in the same cycle; tout stays 0 in that case.
- Release handling:
  - At the release edge the block re-arbitrates in the same cycle.
  - Candidate set = req with bit o cleared. Bit o is cleared on timeout; on voluntary release it is already 0.
  - Candidate set non-zero -> go directly to GRANT with the new winner, hold_cnt=0. No idle bubble between owners.
  - Candidate set zero -> go to IDLE; gnt=0, gnt_vld=0, gnt_idx holds its last value.
  - tout=1 for exactly one cycle after a timeout release, independent of whether a new grant follows.
- Requests from non-owners are ignored while a grant is held; there is no pre-emption.
- Requests are level-sensitive and are not latched. A request dropped before it wins is lost.
- MAX_HOLD=1: each grant lasts exactly one cycle. With several requesters active, ownership changes every cycle.
- Reset mid-grant: gnt drops immediately and asynchronously. After reset deassert, the first arbitration uses the reset priority.
- gnt is always one-hot or zero. gnt_vld==|gnt and gnt==(gnt_vld<<gnt_idx) hold at all times.

Optional Feature:
- Macro: REQ_ARBITER8_ROUND_ROBIN_EN.
- Defined: rotating priority.
  - rr_ptr updates to the winner index at every grant.
  - The search order for the next arbitration is rr_ptr-1, rr_ptr-2, ... down to 0, then wrapping 7 down to rr_ptr (mod 8, descending).
  - The last owner is therefore lowest priority.
  - After reset (rr_ptr=7) the search order is 6,5,...,0,7.
- Not defined: fixed priority, 7 highest ... 0 lowest. rr_ptr is absent. The owner mask on timeout is the only fairness mechanism.

Test Plan:
- Reset: assert rst mid-grant with req=8'hFF -> gnt=0, gnt_vld=0, gnt_idx=0, tout=0 immediately, before the next clk edge.
- Priority, fixed mode: req=8'b0010_0110 from IDLE -> after 1 edge gnt=8'h20, gnt_idx=5, gnt_vld=1.
- Voluntary handoff: owner 5 drops req[5] while req[2:1] stay high -> next edge gnt=8'h04, gnt_idx=2, no IDLE cycle, tout=0.
- Timeout (MAX_HOLD=4): req=8'h81 held constant -> gnt=8'h80 for exactly 4 cycles, then gnt=8'h01 with tout=1 for one cycle. After 4 more cycles gnt=8'h80 again with tout=1.
- Idle return: single req=8'h08 held for 2 cycles then cleared -> gnt=8'h08 for 2 cycles, then gnt=0, gnt_vld=0, gnt_idx stays 3.
- Round-robin (macro defined): req=8'hFF constant, MAX_HOLD=1 -> grant order 6,5,4,3,2,1,0,7,6,..., one per cycle, tout=1 every cycle after the first grant.
